bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 20 ++
 rtl/bcd_add3.sv | 17 +
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   WIDTH   : binary operand width (14 bits covers 0..16383)
//   DIGITS  : number of packed BCD digits on the result
//   MAX_VAL : largest value representable in DIGITS decimal digits
//   CNT_W   : width of the shift-iteration counter
//   state_e : converter FSM states
package bin2bcd_pkg;

    localparam int unsigned WIDTH   = 14;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned MAX_VAL = 9999;
    localparam int unsigned CNT_W   = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
//   digit : 4-bit BCD digit before correction
//   adj   : corrected digit (4-bit result, no carry out)
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    always_comb begin
        adj = digit;
        if (digit >= 4'd5) begin
            adj = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter feeding the seven-segment display
// controller. One shift-and-add-3 iteration per cycle; inputs above MAX_VAL
// are clamped and flagged.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   start : conversion request, only honoured while idle
//   bin   : binary operand, captured on the accepting edge
//   busy  : high from the accepting edge until the result is written
//   done  : one-cycle pulse in the first cycle bcd shows a new result
//   bcd   : packed BCD result, digit 3 in the top nibble; holds last result
//   ovf   : last accepted operand exceeded MAX_VAL
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = bin2bcd_pkg::WIDTH,
    parameter int unsigned DIGITS = bin2bcd_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned BcdW = 4 * DIGITS;

    localparam logic [CntW-1:0]  LastIter = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MaxBin   = WIDTH'(MAX_VAL);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  bin_sr_q, bin_sr_d;
    logic [BcdW-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic              over_max;
    logic [WIDTH-1:0]  bin_clamped;
    logic [BcdW-1:0]   bcd_adj;

    // Clamping to MAX_VAL keeps every digit in 0..9, so the scratch register
    // never needs a spare carry digit.
    assign over_max    = (bin > MaxBin);
    assign bin_clamped = over_max ? MaxBin : bin;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (bcd_sr_q[4*i +: 4]),
            .adj   (bcd_adj[4*i +: 4])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_sr_d = bin_sr_q;
        bcd_sr_d = bcd_sr_q;
        bcd_d    = bcd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bin_sr_d = bin_clamped;
                    bcd_sr_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    ovf_d    = over_max;
                    state_d  = StShift;
                end
            end
            StShift: begin
                // Correct digits first, then shift the whole {bcd, bin} pair.
                {bcd_sr_d, bin_sr_d} = {bcd_adj, bin_sr_q} << 1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastIter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = bcd_sr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bin_sr_q <= '0;
            bcd_sr_q <= '0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_sr_q <= bin_sr_d;
            bcd_sr_q <= bcd_sr_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. A cycle-level timing model decides
// when a start is accepted and pushes the expected result to a scoreboard;
// results are popped and compared when the DUT pulses done.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    always #5 clk = ~clk;

    bin2bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   m_left   = 0;  // cycles until model result; 0 means idle
    bit   m_done   = 1'b0;

    function automatic exp_t model(input int v);
        exp_t e;
        int   c;
        c = (v > 9999) ? 9999 : v;
        e.bcd = {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
        e.ovf = (v > 9999);
        return e;
    endfunction

    // Advance one clock, update the timing model, sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            m_left = 0;
            sb.delete();
        end else if (m_left == 0) begin
            if (start) begin
                sb.push_back(model(int'(bin)));
                m_left  = 15;
                acc_cyc = cyc;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end
        #1;
    endtask

    // Wait for the pending result and compare it against the scoreboard.
    task automatic finish_conv(input string name);
        bit   seen;
        int   lat;
        exp_t e;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            checks++;
            if (done !== m_done) begin
                failures++;
                $display("FAIL %s done_timing cyc=%0d got=%b want=%b", name, cyc, done, m_done);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - acc_cyc;
            end else begin
                tick();
            end
        end
        checks++;
        if (lat != 15) begin
            failures++;
            $display("FAIL %s latency got=%0d want=15", name, lat);
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard got=empty want=entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bcd !== e.bcd) begin
                failures++;
                $display("FAIL %s bcd got=%h want=%h", name, bcd, e.bcd);
            end
            checks++;
            if (ovf !== e.ovf) begin
                failures++;
                $display("FAIL %s ovf got=%b want=%b", name, ovf, e.ovf);
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (bcd[4*d +: 4] > 4'd9) begin
                    failures++;
                    $display("FAIL %s digit%0d got=%0d want<=9", name, d, bcd[4*d +: 4]);
                end
            end
        end
    endtask

    task automatic run_conv(input string name, input int v);
        start = 1'b1;
        bin   = 14'(v);
        tick();
        start = 1'b0;
        bin   = 14'($urandom);
        finish_conv(name);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bcd !== 16'h0000) begin failures++; $display("FAIL rst_bcd got=%h want=0000", bcd); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", done); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b want=0", ovf); end
    endtask

    task automatic test_zero();
        int nb;
        start = 1'b1;
        bin   = 14'd0;
        tick();
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            if (busy === 1'b1) nb++;
            tick();
        end
        checks++;
        if (nb != 15) begin failures++; $display("FAIL zero_busy_len got=%0d want=15", nb); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_at_done got=%b want=0", busy); end
        finish_conv("zero");
    endtask

    task automatic test_back_to_back();
        int first_done;
        run_conv("b2b_1234", 1234);
        first_done = cyc;
        start = 1'b1;
        bin   = 14'd5;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || acc_cyc != first_done + 1) begin
            failures++;
            $display("FAIL b2b_accept got_busy=%b acc=%0d want_busy=1 acc=%0d",
                     busy, acc_cyc, first_done + 1);
        end
        finish_conv("b2b_0005");
    endtask

    task automatic test_clamp();
        run_conv("clamp_9999", 9999);
        run_conv("clamp_12000", 12000);
        run_conv("clamp_42", 42);
    endtask

    task automatic test_hold();
        start = 1'b1;
        bin   = 14'd777;
        tick();
        for (int i = 0; i < 3; i++) tick();
        bin = 14'd888;  // start stays high during SHIFT
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b want=1", busy); end
        finish_conv("hold_777");
        tick();  // done cycle edge: held start is accepted here
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || acc_cyc != cyc) begin
            failures++;
            $display("FAIL hold_reaccept got_busy=%b acc=%0d want_busy=1 acc=%0d", busy, acc_cyc, cyc);
        end
        finish_conv("hold_888");
    endtask

    task automatic test_abort();
        int ndone;
        start = 1'b1;
        bin   = 14'd4321;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bcd !== 16'h0000) begin failures++; $display("FAIL abort_bcd got=%h want=0000", bcd); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL abort_ovf got=%b want=0", ovf); end
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
        run_conv("abort_4321", 4321);
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16384; v += 7) begin
            run_conv($sformatf("sweep_%0d", v), v);
        end
        run_conv("sweep_9998", 9998);
        run_conv("sweep_10000", 10000);
        run_conv("sweep_16383", 16383);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_clamp();
        test_hold();
        test_abort();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
